bsg_mem_1rw_sync_rr_arb: RTL and testbench
==========================================

Name: bsg_mem_1rw_sync_rr_arb

Overview:
Round-robin arbiter and sequencer that shares one synchronous single-port RAM (1 access/cycle, read data valid the cycle after issue) among num_req_p requesters.
- Grants one read or write per cycle.
- Captures read data into a one-entry result slot and returns it, tagged with the requester id, under a valid/yumi handshake.
- Sits between client ports and the RAM macro wrapper.

Parameters:
width_p, 32, data word width
els_p, 64, RAM depth
num_req_p, 2, number of requesters (>=2)
addr_width_lp, clog2(els_p), address width (derived)
lg_num_req_lp, clog2(num_req_p), requester id width (derived)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, asynchronous, active-high
v_i  in  num_req_p  per-requester request valid; held until granted
w_i  in  num_req_p  per-requester 1=write, 0=read
addr_i  in  num_req_p*addr_width_lp  per-requester address, requester k in slice k
data_i  in  num_req_p*width_p  per-requester write data
yumi_o  out  num_req_p  one-hot grant; request consumed this cycle
data_v_o  out  1  read result valid
data_o  out  width_p  read result
data_id_o  out  lg_num_req_lp  requester id that issued the read
data_yumi_i  in  1  consumer accepts result this cycle
mem_v_o  out  1  RAM access enable
mem_w_o  out  1  RAM write enable
mem_addr_o  out  addr_width_lp  RAM address
mem_data_o  out  width_p  RAM write data
mem_data_i  in  width_p  RAM read data, valid only the cycle after a read issue

Behaviour:
- Result slot FSM states:
  - EMPTY: no result held.
  - PEND: read issued last cycle; data_o = mem_data_i.
  - FULL: data_o = hold register.
- data_v_o = (state != EMPTY).
- Read eligibility: read_ok = EMPTY | data_yumi_i. A request with w_i=0 is eligible only when read_ok. Writes are always eligible.
- Arbitration:
  - Grant the first eligible requester scanning from rr_ptr upward, with wraparound.
  - On a grant to k, rr_ptr <= (k+1) mod num_req_p. No grant leaves rr_ptr unchanged.
  - yumi_o, mem_v_o, mem_w_o, mem_addr_o and mem_data_o are combinational from the winner in the same cycle (zero latency).
- Transitions (rd = read granted this cycle):
  - EMPTY: rd -> PEND, else EMPTY.
  - PEND: yumi&rd -> PEND; yumi&~rd -> EMPTY; ~yumi -> FULL, and hold <= mem_data_i.
  - FULL: yumi&rd -> PEND; yumi&~rd -> EMPTY; ~yumi -> FULL.
- data_id register loads the winner id on every read grant.
- Ordering and hazards:
  - A write issued in the PEND cycle is legal; read data is captured before the RAM output can change.
  - Write then read of the same address in consecutive cycles returns the new data.
- Reset (asynchronous):
  - state = EMPTY, rr_ptr = 0, hold = 0, data_id = 0.
  - While reset_i=1: yumi_o=0, mem_v_o=0, data_v_o=0.
  - Reset mid-operation discards any in-flight read without returning it.
- Requester exclusion: a requester with v_i=0 is never granted. Behaviour is undefined if w_i or addr_i changes while v_i=1 before the grant.

Optional Feature:
BSG_MEM_1RW_SYNC_RR_ARB_WRITE_PRIO_EN
- Defined: any eligible write beats all reads. Among writes, round-robin from rr_ptr. rr_ptr updates on every grant as above.
- Undefined: pure round-robin ignoring the read/write type.

Decomposition:
- Package bsg_mem_1rw_sync_rr_arb_pkg: slot state enum typedef (EMPTY/PEND/FULL) and localparam encodings.
- Sub-module bsg_mem_1rw_sync_rr_arb_pick: combinational rotate-priority picker (eligible vector + rr_ptr -> one-hot grant + encoded id). The rr_ptr register stays in the parent.

Test Plan:
- Reset, then req0 and req1 both write (addr 3 / 0xAA, addr 5 / 0xBB) every cycle: grants alternate 0,1,0; RAM holds 0xAA@3 and 0xBB@5.
- req1 reads addr 5 with data_yumi_i tied 1: data_v_o=1 one cycle after grant, data_o=0xBB, data_id_o=1.
- req0 reads addr 3 with data_yumi_i=0 for 4 cycles while req1 writes 0x11@3: state goes FULL, data_o stays 0xAA, req1 write still granted, and a second read by req0 is not granted until yumi.
- Back-to-back reads by req0 (addr 3, then 5) with yumi=1: one read grant per cycle, results 0x11 then 0xBB with no bubble.
- Assert reset_i during PEND: data_v_o=0 immediately; after release, rr_ptr=0 (requester 0 wins a tie) and no stale result appears.
- With WRITE_PRIO_EN: req0 read and req1 write pending together -> req1 granted first. Without it: req0 granted first after reset.

Source files
------------

// File: rtl/bsg_mem_1rw_sync_rr_arb_pkg.sv
// Shared types for the round-robin single-port RAM arbiter: result-slot state encodings.
package bsg_mem_1rw_sync_rr_arb_pkg;

  localparam logic [1:0] SlotEncEmpty = 2'b00;
  localparam logic [1:0] SlotEncPend  = 2'b01;
  localparam logic [1:0] SlotEncFull  = 2'b10;

  typedef enum logic [1:0] {
    StEmpty = SlotEncEmpty,
    StPend  = SlotEncPend,
    StFull  = SlotEncFull
  } slot_state_e;

endpackage

// File: rtl/bsg_mem_1rw_sync_rr_arb_pick.sv
// Combinational rotate-priority picker: first eligible requester at or above rr_ptr_i, with wrap.
module bsg_mem_1rw_sync_rr_arb_pick #(
  parameter int unsigned num_req_p     = 2,
  parameter int unsigned lg_num_req_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]     elig_i,
  input  logic [lg_num_req_lp-1:0] rr_ptr_i,
  output logic [num_req_p-1:0]     grant_o,
  output logic [lg_num_req_lp-1:0] id_o,
  output logic                     v_o
);

  always_comb begin
    logic [lg_num_req_lp-1:0] idx;
    idx     = '0;
    grant_o = '0;
    id_o    = '0;
    v_o     = 1'b0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      idx = lg_num_req_lp'((32'(rr_ptr_i) + i) % num_req_p);
      if (!v_o && elig_i[idx]) begin
        grant_o[idx] = 1'b1;
        id_o         = idx;
        v_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_mem_1rw_sync_rr_arb.sv
// Round-robin sharing of one synchronous 1RW RAM among num_req_p requesters, with a one-entry
// read-result slot. Define BSG_MEM_1RW_SYNC_RR_ARB_WRITE_PRIO_EN to let eligible writes beat reads.
module bsg_mem_1rw_sync_rr_arb
  import bsg_mem_1rw_sync_rr_arb_pkg::*;
#(
  parameter int unsigned width_p       = 32,
  parameter int unsigned els_p         = 64,
  parameter int unsigned num_req_p     = 2,
  localparam int unsigned addr_width_lp = $clog2(els_p),
  localparam int unsigned lg_num_req_lp = $clog2(num_req_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_req_p-1:0]               v_i,
  input  logic [num_req_p-1:0]               w_i,
  input  logic [num_req_p*addr_width_lp-1:0] addr_i,
  input  logic [num_req_p*width_p-1:0]       data_i,
  output logic [num_req_p-1:0]               yumi_o,
  output logic                               data_v_o,
  output logic [width_p-1:0]                 data_o,
  output logic [lg_num_req_lp-1:0]           data_id_o,
  input  logic                               data_yumi_i,
  output logic                               mem_v_o,
  output logic                               mem_w_o,
  output logic [addr_width_lp-1:0]           mem_addr_o,
  output logic [width_p-1:0]                 mem_data_o,
  input  logic [width_p-1:0]                 mem_data_i
);

  slot_state_e              state_q, state_d;
  logic [lg_num_req_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [lg_num_req_lp-1:0] data_id_q, data_id_d;
  logic [width_p-1:0]       hold_q, hold_d;

  logic [num_req_p-1:0]     rd_elig, elig, win_grant;
  logic [lg_num_req_lp-1:0] win_id;
  logic                     win_v, win_w, read_ok, rd;

  // A read may only issue if the slot will be free when its data arrives next cycle.
  assign read_ok = (state_q == StEmpty) | data_yumi_i;
  assign rd_elig = v_i & (w_i | {num_req_p{read_ok}});

`ifdef BSG_MEM_1RW_SYNC_RR_ARB_WRITE_PRIO_EN
  logic [num_req_p-1:0] wr_elig;
  assign wr_elig = v_i & w_i;
  assign elig    = (|wr_elig) ? wr_elig : rd_elig;
`else
  assign elig    = rd_elig;
`endif

  bsg_mem_1rw_sync_rr_arb_pick #(
    .num_req_p    (num_req_p),
    .lg_num_req_lp(lg_num_req_lp)
  ) u_pick (
    .elig_i  (elig),
    .rr_ptr_i(rr_ptr_q),
    .grant_o (win_grant),
    .id_o    (win_id),
    .v_o     (win_v)
  );

  always_comb begin
    win_w      = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      if (win_grant[k]) begin
        win_w      = w_i[k];
        mem_addr_o = addr_i[k*addr_width_lp +: addr_width_lp];
        mem_data_o = data_i[k*width_p +: width_p];
      end
    end
  end

  assign yumi_o  = reset_i ? '0 : win_grant;
  assign mem_v_o = win_v & ~reset_i;
  assign mem_w_o = win_w;
  assign rd      = mem_v_o & ~win_w;

  assign data_v_o  = (state_q != StEmpty) & ~reset_i;
  assign data_o    = (state_q == StPend) ? mem_data_i : hold_q;
  assign data_id_o = data_id_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    data_id_d = data_id_q;
    hold_d    = hold_q;

    if (mem_v_o) begin
      rr_ptr_d = (win_id == lg_num_req_lp'(num_req_p - 1)) ? '0 : win_id + 1'b1;
    end
    if (rd) begin
      data_id_d = win_id;
    end

    unique case (state_q)
      StEmpty: if (rd) state_d = StPend;
      StPend: begin
        if (data_yumi_i) begin
          state_d = rd ? StPend : StEmpty;
        end else begin
          // RAM output is only valid this cycle; latch it before a write can disturb it.
          state_d = StFull;
          hold_d  = mem_data_i;
        end
      end
      StFull:  if (data_yumi_i) state_d = rd ? StPend : StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StEmpty;
      rr_ptr_q  <= '0;
      data_id_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      data_id_q <= data_id_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_rr_arb.sv
// Self-checking bench for bsg_mem_1rw_sync_rr_arb with a behavioural sync RAM and a read scoreboard.
module tb_bsg_mem_1rw_sync_rr_arb;

  localparam int W  = 32;
  localparam int E  = 64;
  localparam int N  = 2;
  localparam int AW = 6;
  localparam int LG = 1;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [LG-1:0] id;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [N-1:0]  v_i, w_i, yumi_o;
  logic [N*AW-1:0] addr_i;
  logic [N*W-1:0]  data_i;
  logic          data_v_o, data_yumi_i, mem_v_o, mem_w_o;
  logic [W-1:0]  data_o, mem_data_o, mem_data_i;
  logic [LG-1:0] data_id_o;
  logic [AW-1:0] mem_addr_o;

  logic [AW-1:0] tb_addr[N];
  logic [W-1:0]  tb_data[N];
  logic [W-1:0]  ram[E];
  logic [W-1:0]  shadow[E];
  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  assign addr_i = {tb_addr[1], tb_addr[0]};
  assign data_i = {tb_data[1], tb_data[0]};

  bsg_mem_1rw_sync_rr_arb #(
    .width_p  (W),
    .els_p    (E),
    .num_req_p(N)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .w_i        (w_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .yumi_o     (yumi_o),
    .data_v_o   (data_v_o),
    .data_o     (data_o),
    .data_id_o  (data_id_o),
    .data_yumi_i(data_yumi_i),
    .mem_v_o    (mem_v_o),
    .mem_w_o    (mem_w_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i)
  );

  // Sync RAM: output is garbage except the cycle after a read.
  always @(posedge clk) begin
    if (mem_v_o && !mem_w_o) mem_data_i <= ram[mem_addr_o];
    else                     mem_data_i <= 32'hDEADBEEF;
    if (mem_v_o && mem_w_o)  ram[mem_addr_o] <= mem_data_o;
  end

  // Scoreboard: push expected data on read grants, pop on accepted results.
  always begin
    @(negedge clk);
    #3;
    if (!reset_i) begin
      if (data_v_o && data_yumi_i) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got data %h id %0d, required no result", data_o, data_id_o);
        end else begin
          mon_e = sb.pop_front();
          if ({data_o, data_id_o} !== mon_e)
            $display("FAIL sb_result: got data %h id %0d, required data %h id %0d",
                     data_o, data_id_o, mon_e.d, mon_e.id);
          else n_pass++;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (yumi_o[k]) begin
          if (w_i[k]) shadow[tb_addr[k]] = tb_data[k];
          else        sb.push_back({shadow[tb_addr[k]], LG'(k)});
        end
      end
    end
  end

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] w, input logic [AW-1:0] a0,
                     input logic [AW-1:0] a1, input logic [W-1:0] d0, input logic [W-1:0] d1,
                     input logic y);
    @(negedge clk);
    v_i = v; w_i = w; tb_addr[0] = a0; tb_addr[1] = a1; tb_data[0] = d0; tb_data[1] = d1;
    data_yumi_i = y;
    #2;
  endtask

  task automatic test_reset();
    @(negedge clk);
    v_i = 2'b11; w_i = 2'b00;
    #2;
    n_checks++;
    if ({yumi_o, mem_v_o, data_v_o, data_id_o} !== 5'b0)
      $display("FAIL reset_outputs: got yumi %b mem_v %b data_v %b id %0d, required all 0",
               yumi_o, mem_v_o, data_v_o, data_id_o);
    else n_pass++;
    @(negedge clk);
    v_i = '0;
    reset_i = 1'b0;
  endtask

  task automatic test_writes();
    logic [N-1:0] exp_g[3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, 2'b11, 6'd3, 6'd5, 32'hAA, 32'hBB, 1'b0);
      n_checks++;
      if (yumi_o !== exp_g[i]) $display("FAIL wr_grant%0d: got %b, required %b", i, yumi_o, exp_g[i]);
      else n_pass++;
      n_checks++;
      if ({mem_v_o, mem_w_o, mem_addr_o, mem_data_o} !==
          {2'b11, exp_g[i][0] ? 6'd3 : 6'd5, exp_g[i][0] ? 32'hAA : 32'hBB})
        $display("FAIL wr_mem%0d: got v%b w%b a%0d d%h", i, mem_v_o, mem_w_o, mem_addr_o, mem_data_o);
      else n_pass++;
    end
    cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (ram[3] !== 32'hAA || ram[5] !== 32'hBB)
      $display("FAIL wr_ram: got %h@3 %h@5, required aa@3 bb@5", ram[3], ram[5]);
    else n_pass++;
  endtask

  task automatic test_read_yumi();
    cyc(2'b10, 2'b00, 6'd0, 6'd5, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (yumi_o !== 2'b10 || data_v_o !== 1'b0 || mem_w_o !== 1'b0 || mem_addr_o !== 6'd5)
      $display("FAIL rd_issue: got yumi %b data_v %b w %b a %0d, required 10 0 0 5",
               yumi_o, data_v_o, mem_w_o, mem_addr_o);
    else n_pass++;
    cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (data_v_o !== 1'b1 || data_o !== 32'hBB || data_id_o !== 1'b1)
      $display("FAIL rd_result: got v %b d %h id %0d, required 1 bb 1", data_v_o, data_o, data_id_o);
    else n_pass++;
    cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (data_v_o !== 1'b0) $display("FAIL rd_drain: got data_v %b, required 0", data_v_o);
    else n_pass++;
  endtask

  task automatic test_hold();
    cyc(2'b01, 2'b00, 6'd3, 6'd0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (yumi_o !== 2'b01) $display("FAIL hold_issue: got yumi %b, required 01", yumi_o);
    else n_pass++;
    cyc(2'b10, 2'b10, 6'd0, 6'd3, 32'h0, 32'h11, 1'b0);
    n_checks++;
    if (yumi_o !== 2'b10 || data_v_o !== 1'b1 || data_o !== 32'hAA)
      $display("FAIL hold_pend: got yumi %b v %b d %h, required 10 1 aa", yumi_o, data_v_o, data_o);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (yumi_o !== 2'b00 || data_v_o !== 1'b1 || data_o !== 32'hAA || data_id_o !== 1'b0)
        $display("FAIL hold_full%0d: got yumi %b v %b d %h id %0d, required 00 1 aa 0",
                 i, yumi_o, data_v_o, data_o, data_id_o);
      else n_pass++;
    end
    cyc(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (yumi_o !== 2'b01 || data_o !== 32'hAA)
      $display("FAIL hold_release: got yumi %b d %h, required 01 aa", yumi_o, data_o);
    else n_pass++;
    cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (data_v_o !== 1'b1 || data_o !== 32'hBB)
      $display("FAIL hold_next: got v %b d %h, required 1 bb", data_v_o, data_o);
    else n_pass++;
    cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (data_v_o !== 1'b0) $display("FAIL hold_empty: got data_v %b, required 0", data_v_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    cyc(2'b01, 2'b00, 6'd3, 6'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (yumi_o !== 2'b01 || data_v_o !== 1'b0)
      $display("FAIL b2b_first: got yumi %b v %b, required 01 0", yumi_o, data_v_o);
    else n_pass++;
    cyc(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (yumi_o !== 2'b01 || data_v_o !== 1'b1 || data_o !== 32'h11)
      $display("FAIL b2b_second: got yumi %b v %b d %h, required 01 1 11", yumi_o, data_v_o, data_o);
    else n_pass++;
    cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (data_v_o !== 1'b1 || data_o !== 32'hBB || data_id_o !== 1'b0)
      $display("FAIL b2b_result: got v %b d %h id %0d, required 1 bb 0", data_v_o, data_o, data_id_o);
    else n_pass++;
  endtask

  task automatic test_wr_rd();
    cyc(2'b10, 2'b10, 6'd0, 6'd7, 32'h0, 32'h77, 1'b1);
    n_checks++;
    if (yumi_o !== 2'b10) $display("FAIL wrrd_wr: got yumi %b, required 10", yumi_o);
    else n_pass++;
    cyc(2'b01, 2'b00, 6'd7, 6'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (yumi_o !== 2'b01) $display("FAIL wrrd_rd: got yumi %b, required 01", yumi_o);
    else n_pass++;
    cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (data_o !== 32'h77) $display("FAIL wrrd_data: got %h, required 77", data_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cyc(2'b01, 2'b00, 6'd3, 6'd0, 32'h0, 32'h0, 1'b0);
    cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (data_v_o !== 1'b1) $display("FAIL rstmid_pend: got data_v %b, required 1", data_v_o);
    else n_pass++;
    reset_i = 1'b1;
    v_i = 2'b11; w_i = 2'b00; tb_addr[0] = 6'd3; tb_addr[1] = 6'd5; data_yumi_i = 1'b1;
    #1;
    n_checks++;
    if (data_v_o !== 1'b0 || yumi_o !== 2'b00 || mem_v_o !== 1'b0)
      $display("FAIL rstmid_async: got v %b yumi %b mem_v %b, required 0 00 0",
               data_v_o, yumi_o, mem_v_o);
    else n_pass++;
    #2;
    sb.delete();
    @(negedge clk);
    reset_i = 1'b0;
    #2;
    n_checks++;
    if (yumi_o !== 2'b01 || data_v_o !== 1'b0)
      $display("FAIL rstmid_tie: got yumi %b v %b, required 01 0", yumi_o, data_v_o);
    else n_pass++;
    cyc(2'b10, 2'b00, 6'd3, 6'd5, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (yumi_o !== 2'b10 || data_o !== 32'h11 || data_id_o !== 1'b0)
      $display("FAIL rstmid_after: got yumi %b d %h id %0d, required 10 11 0",
               yumi_o, data_o, data_id_o);
    else n_pass++;
    cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b1);
    cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_prio();
    logic [N-1:0] first, second;
`ifdef BSG_MEM_1RW_SYNC_RR_ARB_WRITE_PRIO_EN
    first = 2'b10; second = 2'b01;
`else
    first = 2'b01; second = 2'b10;
`endif
    @(negedge clk);
    reset_i = 1'b1; v_i = '0;
    @(negedge clk);
    reset_i = 1'b0;
    cyc(2'b11, 2'b10, 6'd3, 6'd9, 32'h0, 32'h22, 1'b1);
    n_checks++;
    if (yumi_o !== first) $display("FAIL prio_first: got yumi %b, required %b", yumi_o, first);
    else n_pass++;
    cyc(second, 2'b10, 6'd3, 6'd9, 32'h0, 32'h22, 1'b1);
    n_checks++;
    if (yumi_o !== second) $display("FAIL prio_second: got yumi %b, required %b", yumi_o, second);
    else n_pass++;
    for (int i = 0; i < 3; i++) cyc(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (ram[9] !== 32'h22) $display("FAIL prio_ram: got %h@9, required 22", ram[9]);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < E; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    reset_i = 1'b1;
    v_i = '0; w_i = '0; data_yumi_i = 1'b0;
    tb_addr[0] = '0; tb_addr[1] = '0; tb_data[0] = '0; tb_data[1] = '0;
    test_reset();
    test_writes();
    test_read_yumi();
    test_hold();
    test_back_to_back();
    test_wr_rd();
    test_reset_mid();
    test_prio();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
